string_packer: RTL and testbench

STRING_PACKER -- requirements
Module: string_packer

---
 rtl/string_packer.sv | 134 +++++++++++++
 tb/tb_string_packer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/string_packer.sv
// Packs a stream of 7-bit character codes into an 11-character, 77-bit string.
// Optional inter-character timeout is compiled in when STRING_PACKER_TIMEOUT_EN is defined.
module string_packer #(
   parameter int unsigned READY_CYCLES = 4,
   parameter logic [6:0]  TERM         = 7'h0D,
   parameter int unsigned TIMEOUT      = 25000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  CharIn,
   input  logic        char_valid,
   output logic [0:76] String,
   output logic        ready,
   output logic        overrun
);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t      state_q, state_d;
   logic [0:76] work_q, work_d;
   logic [0:76] string_d;
   logic [3:0]  slot_q, slot_d;
   logic [7:0]  rdy_cnt_q, rdy_cnt_d;
   logic        ready_d;
   logic        overrun_d;
   logic        accept;
   logic        is_term;
   logic        complete;
   logic [6:0]  base;
`ifdef STRING_PACKER_TIMEOUT_EN
   logic [31:0] to_cnt_q, to_cnt_d;
`endif

   if (READY_CYCLES < 1 || READY_CYCLES > 255) begin : g_bad_ready_cycles
      $error("string_packer: READY_CYCLES must be 1..255");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("string_packer: TIMEOUT must be at least 1");
   end

   // The working buffer is zeroed when a string starts, so early completion
   // (terminator or timeout) needs no explicit padding step.
   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      slot_d    = slot_q;
      rdy_cnt_d = rdy_cnt_q;
      string_d  = String;
      ready_d   = ready;
      overrun_d = overrun;
      complete  = 1'b0;
      accept    = char_valid && (CharIn != 7'd0);
      is_term   = (CharIn == TERM);
      base      = 7'(slot_q) * 7'd7;
`ifdef STRING_PACKER_TIMEOUT_EN
      to_cnt_d  = '0;
`endif

      unique case (state_q)
         IDLE: begin
            if (accept && !is_term) begin
               work_d      = '0;
               work_d[0:6] = CharIn;
               slot_d      = 4'd1;
               state_d     = FILL;
            end
         end
         FILL: begin
            if (accept && is_term) begin
               complete = 1'b1;
            end else if (accept) begin
               work_d[base +: 7] = CharIn;
               slot_d            = slot_q + 4'd1;
               if (slot_q == 4'd10) begin
                  complete = 1'b1;
               end
            end
`ifdef STRING_PACKER_TIMEOUT_EN
            else if (to_cnt_q == 32'(TIMEOUT - 1)) begin
               complete = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 32'd1;
            end
`endif
            if (complete) begin
               string_d  = work_d;
               ready_d   = 1'b1;
               rdy_cnt_d = 8'(READY_CYCLES - 1);
               slot_d    = 4'd0;
               state_d   = DONE;
            end
         end
         DONE: begin
            if (accept) begin
               overrun_d = 1'b1;
            end
            if (rdy_cnt_q == 8'd0) begin
               ready_d = 1'b0;
               state_d = IDLE;
            end else begin
               rdy_cnt_d = rdy_cnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         work_q    <= '0;
         slot_q    <= '0;
         rdy_cnt_q <= '0;
         String    <= '0;
         ready     <= 1'b0;
         overrun   <= 1'b0;
`ifdef STRING_PACKER_TIMEOUT_EN
         to_cnt_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         work_q    <= work_d;
         slot_q    <= slot_d;
         rdy_cnt_q <= rdy_cnt_d;
         String    <= string_d;
         ready     <= ready_d;
         overrun   <= overrun_d;
`ifdef STRING_PACKER_TIMEOUT_EN
         to_cnt_q  <= to_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_string_packer.sv
// Directed, table-driven bench for string_packer, plus hand-written sequences
// for asynchronous reset and the inter-character timeout.
module tb_string_packer;

   localparam int unsigned READY_CYCLES = 4;
   localparam logic [6:0]  TERM         = 7'h0D;
   localparam int unsigned TIMEOUT      = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  char_in;
   logic        char_valid;
   logic [0:76] str;
   logic        ready;
   logic        overrun;

   string_packer #(
      .READY_CYCLES(READY_CYCLES),
      .TERM        (TERM),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .CharIn    (char_in),
      .char_valid(char_valid),
      .String    (str),
      .ready     (ready),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        valid;
      logic [6:0]  ch;
      logic        exp_ready;
      logic        exp_overrun;
      logic [0:76] exp_str;
   } vec_t;

   vec_t        vecs[$];
   logic [0:76] exp_s;
   int          n_vec = 0;
   int          n_err = 0;

   function automatic logic [0:76] pack(input string s);
      logic [0:76] r;
      byte         b;
      r = '0;
      for (int i = 0; i < s.len() && i < 11; i++) begin
         b = s[i];
         r[7*i +: 7] = b[6:0];
      end
      return r;
   endfunction

   task automatic add(input logic r, input logic v, input logic [6:0] c,
                      input logic er, input logic eo);
      vec_t t;
      t.rst_n       = r;
      t.valid       = v;
      t.ch          = c;
      t.exp_ready   = er;
      t.exp_overrun = eo;
      t.exp_str     = exp_s;
      vecs.push_back(t);
   endtask

   task automatic add_chars(input string s, input logic eo);
      byte b;
      for (int i = 0; i < s.len(); i++) begin
         b = s[i];
         add(1'b1, 1'b1, b[6:0], 1'b0, eo);
      end
   endtask

   // Completion edge is queued by the caller; ready stays up three more edges.
   task automatic add_window(input logic eo);
      add(1'b1, 1'b0, 7'h00, 1'b1, eo);
      add(1'b1, 1'b0, 7'h00, 1'b1, eo);
      add(1'b1, 1'b0, 7'h00, 1'b1, eo);
      add(1'b1, 1'b0, 7'h00, 1'b0, eo);
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic check_str(input string name, input logic [0:76] act, input logic [0:76] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input vec_t t, input int idx);
      @(negedge clk);
      reset      = t.rst_n;
      char_valid = t.valid;
      char_in    = t.ch;
      @(posedge clk);
      #1;
      check_bit($sformatf("vec%0d ready", idx), ready, t.exp_ready);
      check_bit($sformatf("vec%0d overrun", idx), overrun, t.exp_overrun);
      check_str($sformatf("vec%0d string", idx), str, t.exp_str);
   endtask

   task automatic drive_char(input logic [6:0] c);
      @(negedge clk);
      char_valid = 1'b1;
      char_in    = c;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic exp_r;
      logic [0:76] exp_t;
      string hw;
      byte b;

      reset      = 1'b0;
      char_valid = 1'b0;
      char_in    = 7'h00;
      exp_s      = '0;

      // Reset state, and a character offered during reset must be ignored
      add(1'b0, 1'b0, 7'h00, 1'b0, 1'b0);
      add(1'b0, 1'b1, 7'h41, 1'b0, 1'b0);
      add(1'b1, 1'b0, 7'h00, 1'b0, 1'b0);

      // Full 11-character string
      add_chars("HELLO WORL", 1'b0);
      exp_s = pack("HELLO WORLD");
      add(1'b1, 1'b1, 7'h44, 1'b1, 1'b0);
      add_window(1'b0);

      // Terminator in IDLE is ignored; short string ended by terminator
      add(1'b1, 1'b1, TERM, 1'b0, 1'b0);
      add_chars("HI", 1'b0);
      exp_s = pack("HI");
      add(1'b1, 1'b1, TERM, 1'b1, 1'b0);
      add_window(1'b0);

      // Null code consumes no slot
      add_chars("AB", 1'b0);
      add(1'b1, 1'b1, 7'h00, 1'b0, 1'b0);
      add_chars("C", 1'b0);
      exp_s = pack("ABC");
      add(1'b1, 1'b1, TERM, 1'b1, 1'b0);
      add_window(1'b0);

      // Character arriving in DONE is dropped and overrun sticks
      add_chars("ABCDEFGHIJ", 1'b0);
      exp_s = pack("ABCDEFGHIJK");
      add(1'b1, 1'b1, 7'h4B, 1'b1, 1'b0);
      add(1'b1, 1'b1, 7'h58, 1'b1, 1'b1);
      add(1'b1, 1'b0, 7'h00, 1'b1, 1'b1);
      add(1'b1, 1'b0, 7'h00, 1'b1, 1'b1);
      add(1'b1, 1'b0, 7'h00, 1'b0, 1'b1);
      add_chars("Q", 1'b1);
      exp_s = pack("Q");
      add(1'b1, 1'b1, TERM, 1'b1, 1'b1);
      add_window(1'b1);

      // Reset in the middle of a string discards it and clears overrun
      add_chars("ABCDE", 1'b1);
      exp_s = '0;
      add(1'b0, 1'b0, 7'h00, 1'b0, 1'b0);
      add(1'b1, 1'b0, 7'h00, 1'b0, 1'b0);
      add_chars("XYZ", 1'b0);
      exp_s = pack("XYZ");
      add(1'b1, 1'b1, TERM, 1'b1, 1'b0);
      add_window(1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i], i);
      end

      // Asynchronous reset during DONE clears outputs without a clock edge
      hw = "HELLO WORLD";
      for (int i = 0; i < 11; i++) begin
         b = hw[i];
         drive_char(b[6:0]);
      end
      @(posedge clk);
      #1;
      check_bit("async ready before reset", ready, 1'b1);
      check_str("async string before reset", str, pack("HELLO WORLD"));
      drive_char(7'h58);
      @(posedge clk);
      #1;
      check_bit("async overrun before reset", overrun, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check_bit("async ready", ready, 1'b0);
      check_bit("async overrun", overrun, 1'b0);
      check_str("async string", str, '0);
      @(negedge clk);
      reset      = 1'b1;
      char_valid = 1'b0;
      char_in    = 7'h00;

      // Inter-character timeout after "OK"
      drive_char(7'h4F);
      drive_char(7'h4B);
      @(posedge clk);
      @(negedge clk);
      char_valid = 1'b0;
      char_in    = 7'h00;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
`ifdef STRING_PACKER_TIMEOUT_EN
         exp_r = (k >= 16 && k <= 19);
         exp_t = (k >= 16) ? pack("OK") : '0;
`else
         exp_r = 1'b0;
         exp_t = '0;
`endif
         check_bit($sformatf("timeout k=%0d ready", k), ready, exp_r);
         check_str($sformatf("timeout k=%0d string", k), str, exp_t);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
